// File: rtl/inst_loader_if.sv
// Byte-stream, boot-control and inst_mem write bundle for inst_loader.
// The slave modport is the loader side; master is the feeding/observing side.
interface inst_loader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              start;
    logic              s_valid;
    logic              s_ready;
    logic [7:0]        s_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              core_rst_n;
    logic              done;
    logic              err;

    modport slave (
        input  start, s_valid, s_data,
        output s_ready, mem_we, mem_addr, mem_wdata, core_rst_n, done, err
    );

    modport master (
        output start, s_valid, s_data,
        input  s_ready, mem_we, mem_addr, mem_wdata, core_rst_n, done, err
    );
endinterface

// File: rtl/inst_loader.sv
// inst_loader: boot loader in front of the rvseed inst_mem.
// Takes a framed byte stream (LEN_LO, LEN_HI, N little-endian data words),
// writes the words to inst_mem and releases core reset once the image is in.
// Optional trailing XOR checksum byte: define INST_LOADER_CSUM_EN.
module inst_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    inst_loader_if.slave bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int WC_W  = ADDR_W + 1;

    typedef enum logic [2:0] {
        ST_LEN0 = 3'd0,
        ST_LEN1 = 3'd1,
        ST_DATA = 3'd2,
`ifdef INST_LOADER_CSUM_EN
        ST_CSUM = 3'd3,
`endif
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    state_t            state;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [BC_W-1:0]   byte_cnt;
    logic [WC_W-1:0]   word_cnt;
    logic [DATA_W-1:0] asm_word;
`ifdef INST_LOADER_CSUM_EN
    logic [7:0]        csum;
`endif

    logic              take;
    logic [15:0]       n_full;
    logic [DATA_W-1:0] word_full;
    logic              last_byte;
    logic              last_word;

    // Handshake decode, incoming length and the word as it looks with the current byte merged in
    always_comb begin
        take      = bus.s_valid & bus.s_ready;
        n_full    = {bus.s_data, len_lo};
        last_byte = (byte_cnt == BC_W'(BYTES - 1));
        last_word = ((32'(word_cnt) + 32'd1) == 32'(len));
        word_full = asm_word;
        for (int k = 0; k < BYTES; k++) begin
            if (byte_cnt == BC_W'(k)) begin
                word_full[8*k +: 8] = bus.s_data;
            end else begin
                word_full[8*k +: 8] = asm_word[8*k +: 8];
            end
        end
    end

    // Loader FSM with all outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_LEN0;
            len_lo         <= 8'h00;
            len            <= 16'h0000;
            byte_cnt       <= '0;
            word_cnt       <= '0;
            asm_word       <= '0;
`ifdef INST_LOADER_CSUM_EN
            csum           <= 8'h00;
`endif
            bus.s_ready    <= 1'b1;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.core_rst_n <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                ST_LEN0: begin
                    if (take) begin
                        len_lo <= bus.s_data;
                        state  <= ST_LEN1;
                    end
                end
                ST_LEN1: begin
                    if (take) begin
                        len <= n_full;
                        // An image larger than inst_mem can never be placed: refuse it up front
                        if (32'(n_full) > (32'd1 << ADDR_W)) begin
                            state       <= ST_ERR;
                            bus.s_ready <= 1'b0;
                            bus.err     <= 1'b1;
                        end else if (n_full == 16'h0000) begin
`ifdef INST_LOADER_CSUM_EN
                            state          <= ST_CSUM;
`else
                            state          <= ST_DONE;
                            bus.s_ready    <= 1'b0;
                            bus.done       <= 1'b1;
                            bus.core_rst_n <= 1'b1;
`endif
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (take) begin
                        asm_word <= word_full;
`ifdef INST_LOADER_CSUM_EN
                        csum     <= csum ^ bus.s_data;
`endif
                        if (last_byte) begin
                            byte_cnt      <= '0;
                            word_cnt      <= word_cnt + WC_W'(1);
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= word_cnt[ADDR_W-1:0];
                            bus.mem_wdata <= word_full;
                            if (last_word) begin
`ifdef INST_LOADER_CSUM_EN
                                state          <= ST_CSUM;
`else
                                state          <= ST_DONE;
                                bus.s_ready    <= 1'b0;
                                bus.done       <= 1'b1;
                                bus.core_rst_n <= 1'b1;
`endif
                            end
                        end else begin
                            byte_cnt <= byte_cnt + BC_W'(1);
                        end
                    end
                end
`ifdef INST_LOADER_CSUM_EN
                ST_CSUM: begin
                    if (take) begin
                        bus.s_ready <= 1'b0;
                        if (bus.s_data == csum) begin
                            state          <= ST_DONE;
                            bus.done       <= 1'b1;
                            bus.core_rst_n <= 1'b1;
                        end else begin
                            state   <= ST_ERR;
                            bus.err <= 1'b1;
                        end
                    end
                end
`endif
                ST_DONE, ST_ERR: begin
                    // Re-arm for a new image; inst_mem contents and mem_addr/mem_wdata are left alone
                    if (bus.start) begin
                        state          <= ST_LEN0;
                        byte_cnt       <= '0;
                        word_cnt       <= '0;
                        asm_word       <= '0;
`ifdef INST_LOADER_CSUM_EN
                        csum           <= 8'h00;
`endif
                        bus.s_ready    <= 1'b1;
                        bus.core_rst_n <= 1'b0;
                        bus.done       <= 1'b0;
                        bus.err        <= 1'b0;
                    end
                end
                default: begin
                    state          <= ST_ERR;
                    bus.s_ready    <= 1'b0;
                    bus.core_rst_n <= 1'b0;
                    bus.done       <= 1'b0;
                    bus.err        <= 1'b1;
                end
            endcase
        end
    end
endmodule
